// File: rtl/ram_handshake_responder.sv
// Memory-side responder for the MOV/RW/MOC handshake: a 512x8 big-endian byte
// store with programmable wait states, MIPS load/store size/sign handling and an error flag.
//
// Ports:
//   clk      - system clock, all state changes on the rising edge
//   reset    - synchronous active-low; clears FSM and outputs, never memory
//   MOV      - request valid, held by the initiator until MOC is seen
//   RW       - 1 = load, 0 = store
//   OpC      - MIPS opcode (LB/LH/LW/LBU/LHU/SB/SH/SW)
//   Address  - byte address
//   DataIn   - store data (byte/half taken from the low bits)
//   DataOut  - load result, valid while MOC=1 (zero for stores and errors)
//   MOC      - memory operation complete
//   MERR     - error qualifier, valid while MOC=1
module ram_handshake_responder #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DEPTH   = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MOV,
    input  logic        RW,
    input  logic [5:0]  OpC,
    input  logic [8:0]  Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        MERR
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_e;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic        rw_q, rw_d;
    logic [5:0]  opc_q, opc_d;
    logic [8:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] dout_q, dout_d;
    logic        moc_q, moc_d;
    logic        merr_q, merr_d;

    logic [7:0]  mem [DEPTH];

    // Decode of the captured request
    logic        is_ld, is_st, sx, known, misalign, err;
    size_e       size;
    logic [8:0]  a1, a2, a3;
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] rdata;
    logic        access, wr_en;

    always_comb begin
        is_ld = 1'b0;
        is_st = 1'b0;
        sx    = 1'b0;
        known = 1'b1;
        size  = SZ_B;
        case (opc_q)
            6'b100000: begin is_ld = 1'b1; size = SZ_B; sx = 1'b1; end
            6'b100001: begin is_ld = 1'b1; size = SZ_H; sx = 1'b1; end
            6'b100011: begin is_ld = 1'b1; size = SZ_W;            end
            6'b100100: begin is_ld = 1'b1; size = SZ_B;            end
            6'b100101: begin is_ld = 1'b1; size = SZ_H;            end
            6'b101000: begin is_st = 1'b1; size = SZ_B;            end
            6'b101001: begin is_st = 1'b1; size = SZ_H;            end
            6'b101011: begin is_st = 1'b1; size = SZ_W;            end
            default:   known = 1'b0;
        endcase

        misalign = ((size == SZ_H) && addr_q[0]) ||
                   ((size == SZ_W) && (addr_q[1:0] != 2'b00));
        err = !known || (is_ld && !rw_q) || (is_st && rw_q) || misalign;

        // Aligned accesses never cross the top of memory, so the
        // 9-bit wrap of these sums is only ever seen by erroring requests.
        a1 = addr_q + 9'd1;
        a2 = addr_q + 9'd2;
        a3 = addr_q + 9'd3;
        b0 = mem[addr_q];
        b1 = mem[a1];
        b2 = mem[a2];
        b3 = mem[a3];

        case (size)
            SZ_B:    rdata = {{24{sx & b0[7]}}, b0};
            SZ_H:    rdata = {{16{sx & b0[7]}}, b0, b1};
            default: rdata = {b0, b1, b2, b3};
        endcase

        access = (state_q == S_WAIT) && (count_q == 4'd0) && MOV;
        wr_en  = reset && access && is_st && !err;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rw_d    = rw_q;
        opc_d   = opc_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        moc_d   = moc_q;
        merr_d  = merr_q;
        case (state_q)
            S_IDLE: begin
                if (MOV) begin
                    rw_d    = RW;
                    opc_d   = OpC;
                    addr_d  = Address;
                    wdata_d = DataIn;
                    count_d = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Dropping MOV before completion abandons the request
                if (!MOV) begin
                    state_d = S_IDLE;
                    count_d = 4'd0;
                end else if (count_q == 4'd0) begin
                    state_d = S_DONE;
                    moc_d   = 1'b1;
                    merr_d  = err;
                    dout_d  = (err || is_st) ? 32'd0 : rdata;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            S_DONE: begin
                if (!MOV) begin
                    state_d = S_IDLE;
                    moc_d   = 1'b0;
                    merr_d  = 1'b0;
                    dout_d  = 32'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                moc_d   = 1'b0;
                merr_d  = 1'b0;
                dout_d  = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= 4'd0;
            rw_q    <= 1'b0;
            opc_q   <= 6'd0;
            addr_q  <= 9'd0;
            wdata_q <= 32'd0;
            dout_q  <= 32'd0;
            moc_q   <= 1'b0;
            merr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rw_q    <= rw_d;
            opc_q   <= opc_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            moc_q   <= moc_d;
            merr_q  <= merr_d;
        end
    end

    // Storage is not reset; a word store commits all four bytes on one edge
    always_ff @(posedge clk) begin
        if (wr_en) begin
            case (size)
                SZ_B: begin
                    mem[addr_q] <= wdata_q[7:0];
                end
                SZ_H: begin
                    mem[addr_q] <= wdata_q[15:8];
                    mem[a1]     <= wdata_q[7:0];
                end
                default: begin
                    mem[addr_q] <= wdata_q[31:24];
                    mem[a1]     <= wdata_q[23:16];
                    mem[a2]     <= wdata_q[15:8];
                    mem[a3]     <= wdata_q[7:0];
                end
            endcase
        end
    end

    assign DataOut = dout_q;
    assign MOC     = moc_q;
    assign MERR    = merr_q;

endmodule
